// File: rtl/bch_t1_stream_dec_if.sv
// Packet stream bundle for the t=1 BCH decoder: codeword beats in, corrected beats and status out.
// The slave modport is the decoder's view; master is the upstream source plus downstream sink.
interface bch_t1_stream_dec_if #(
   parameter int unsigned DATA_W = 5
) ();
   logic              load;
   logic              ready;
   logic              sop_in;
   logic              eop_in;
   logic [DATA_W-1:0] data_in;
   logic              valid_out;
   logic              sink_ready;
   logic              sop_out;
   logic              eop_out;
   logic [DATA_W-1:0] data_out;
   logic [1:0]        number_errors;

   modport master (
      output load, sop_in, eop_in, data_in, sink_ready,
      input  ready, valid_out, sop_out, eop_out, data_out, number_errors
   );

   modport slave (
      input  load, sop_in, eop_in, data_in, sink_ready,
      output ready, valid_out, sop_out, eop_out, data_out, number_errors
   );
endinterface

// File: rtl/bch_t1_stream_dec.sv
// Streaming single-error-correcting binary BCH decoder: on-the-fly syndrome, serial
// Chien-style locator search, buffered and back-pressurable corrected output.
module bch_t1_stream_dec #(
   parameter int unsigned M         = 4,
   parameter int unsigned N         = 15,
   parameter int unsigned DATA_W    = 5,
   parameter logic [M:0]  PRIM_POLY = 5'b10011
) (
   input logic                i_clk,
   input logic                i_rst_n,
   bch_t1_stream_dec_if.slave io_strm
);

   localparam int unsigned B     = N / DATA_W;
   localparam int unsigned CNT_W = $clog2(B + 1);
   localparam int unsigned POS_W = (N > 1) ? $clog2(N) : 1;

   localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(B - 1);
   localparam logic [POS_W-1:0] LAST_POS  = POS_W'(N - 1);

   localparam logic [1:0] IDLE    = 2'd0;
   localparam logic [1:0] RECEIVE = 2'd1;
   localparam logic [1:0] SEARCH  = 2'd2;
   localparam logic [1:0] OUTPUT  = 2'd3;

   localparam logic [1:0] NE_CLEAN  = 2'd0;
   localparam logic [1:0] NE_ONE    = 2'd1;
   localparam logic [1:0] NE_UNCORR = 2'd2;
   localparam logic [1:0] NE_FRAME  = 2'd3;

   function automatic logic [M-1:0] f_mul_alpha(input logic [M-1:0] s);
      return {s[M-2:0], 1'b0} ^ (s[M-1] ? PRIM_POLY[M-1:0] : '0);
   endfunction

   // Horner step per bit, MSB of the beat first.
   function automatic logic [M-1:0] f_syn_beat(input logic [M-1:0] s, input logic [DATA_W-1:0] d);
      logic [M-1:0] v;
      v = s;
      for (int k = DATA_W - 1; k >= 0; k--) begin
         v = f_mul_alpha(v) ^ M'(d[k]);
      end
      return v;
   endfunction

   logic [1:0]        r_state;
   logic              r_ready;
   logic [M-1:0]      r_syn;
   logic [N-1:0]      r_buf;
   logic [CNT_W-1:0]  r_bcnt;
   logic [CNT_W-1:0]  r_nbeats;
   logic [1:0]        r_status;
   logic [M-1:0]      r_loc;
   logic [POS_W-1:0]  r_pos;
   logic [CNT_W-1:0]  r_ocnt;
   logic              r_valid;
   logic              r_sop;
   logic              r_eop;
   logic [DATA_W-1:0] r_dout;
   logic [1:0]        r_nerr;

   logic [1:0]        w_state_d;
   logic              w_take;
   logic [CNT_W-1:0]  w_b;
   logic [M-1:0]      w_syn_new;
   logic              w_last;
   logic              w_close;
   logic              w_frame;
   logic              w_hit;
   logic              w_exhaust;
   logic              w_out_adv;
   logic              w_out_more;
   logic [POS_W-1:0]  w_wbase;
   logic [POS_W-1:0]  w_rbase;

   always_comb begin
      // ready is only high in IDLE/RECEIVE; IDLE ignores beats lacking sop_in.
      w_take     = io_strm.load && r_ready && (io_strm.sop_in || r_state == RECEIVE);
      w_b        = io_strm.sop_in ? '0 : r_bcnt;
      w_syn_new  = f_syn_beat(io_strm.sop_in ? '0 : r_syn, io_strm.data_in);
      w_last     = (w_b == LAST_BEAT);
      w_close    = w_take && (w_last || io_strm.eop_in);
      w_frame    = !(w_last && io_strm.eop_in);
      w_hit      = (r_state == SEARCH) && (r_loc == r_syn);
      w_exhaust  = (r_state == SEARCH) && (r_pos == LAST_POS);
      w_out_adv  = (r_state == OUTPUT) && (!r_valid || io_strm.sink_ready);
      w_out_more = (r_ocnt < r_nbeats);
      w_wbase    = POS_W'((B - 1 - 32'(w_b)) * DATA_W);
      w_rbase    = POS_W'((B - 1 - 32'(r_ocnt)) * DATA_W);
   end

   always_comb begin
      w_state_d = r_state;
      case (r_state)
         IDLE, RECEIVE: begin
            if (w_close) begin
               w_state_d = (w_frame || (w_syn_new == '0)) ? OUTPUT : SEARCH;
            end else if (w_take) begin
               w_state_d = RECEIVE;
            end
         end
         SEARCH: begin
            if (w_hit || w_exhaust) begin
               w_state_d = OUTPUT;
            end
         end
         OUTPUT: begin
            if (w_out_adv && !w_out_more) begin
               w_state_d = IDLE;
            end
         end
         default: w_state_d = IDLE;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state  <= IDLE;
         r_ready  <= 1'b0;
         r_syn    <= '0;
         r_buf    <= '0;
         r_bcnt   <= '0;
         r_nbeats <= '0;
         r_status <= NE_CLEAN;
         r_loc    <= '0;
         r_pos    <= '0;
         r_ocnt   <= '0;
         r_valid  <= 1'b0;
         r_sop    <= 1'b0;
         r_eop    <= 1'b0;
         r_dout   <= '0;
         r_nerr   <= NE_CLEAN;
      end else begin
         r_state <= w_state_d;
         r_ready <= (w_state_d == IDLE) || (w_state_d == RECEIVE);

         if (w_take) begin
            r_syn                       <= w_syn_new;
            r_buf[w_wbase +: DATA_W]    <= io_strm.data_in;
            r_bcnt                      <= w_b + 1'b1;
         end

         // UNCORR is provisional; a locator hit overrides it with ONE.
         if (w_close) begin
            r_nbeats <= w_b + 1'b1;
            r_ocnt   <= '0;
            r_loc    <= M'(1);
            r_pos    <= '0;
            if (w_frame) begin
               r_status <= NE_FRAME;
            end else if (w_syn_new == '0) begin
               r_status <= NE_CLEAN;
            end else begin
               r_status <= NE_UNCORR;
            end
         end

         if (r_state == SEARCH) begin
            if (w_hit) begin
               r_status     <= NE_ONE;
               r_buf[r_pos] <= ~r_buf[r_pos];
            end else begin
               r_loc <= f_mul_alpha(r_loc);
               r_pos <= r_pos + 1'b1;
            end
         end

         if (w_out_adv) begin
            if (w_out_more) begin
               r_valid <= 1'b1;
               r_dout  <= r_buf[w_rbase +: DATA_W];
               r_sop   <= (r_ocnt == '0);
               r_eop   <= (r_ocnt == r_nbeats - 1'b1);
               r_nerr  <= r_status;
               r_ocnt  <= r_ocnt + 1'b1;
            end else begin
               r_valid <= 1'b0;
               r_sop   <= 1'b0;
               r_eop   <= 1'b0;
            end
         end
      end
   end

   assign io_strm.ready         = r_ready;
   assign io_strm.valid_out     = r_valid;
   assign io_strm.sop_out       = r_sop;
   assign io_strm.eop_out       = r_eop;
   assign io_strm.data_out      = r_dout;
   assign io_strm.number_errors = r_nerr;

endmodule

// File: tb/tb_bch_t1_stream_dec.sv
// Bench for bch_t1_stream_dec: GF(16) reference model from r(alpha) = sum of alpha^i,
// a scoreboard queue checked every valid cycle, and directed plus random packets.
module tb_bch_t1_stream_dec;

   localparam int DW = 5;
   localparam int NN = 15;
   localparam int BB = 3;

   typedef struct {
      logic [4:0] data;
      logic       sop;
      logic       eop;
      logic [1:0] nerr;
   } beat_t;

   logic  clk   = 1'b0;
   logic  rst_n = 1'b1;
   beat_t exp_q[$];
   int    n_cmp     = 0;
   int    n_bad     = 0;
   int    sink_mode = 0;
   int    gap_max   = 0;
   int    stall     = 0;

   always #5 clk = ~clk;

   bch_t1_stream_dec_if #(.DATA_W(5)) bus ();
   bch_t1_stream_dec_if #(.DATA_W(4)) bus2 ();

   bch_t1_stream_dec #(.M(4), .N(15), .DATA_W(5), .PRIM_POLY(5'b10011)) dut (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .io_strm (bus)
   );

   bch_t1_stream_dec #(.M(4), .N(12), .DATA_W(4), .PRIM_POLY(5'b10011)) dut2 (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .io_strm (bus2)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [3:0] alpha_pow(input int e);
      logic [3:0] v;
      v = 4'd1;
      for (int i = 0; i < e; i++) v = {v[2:0], 1'b0} ^ (v[3] ? 4'b0011 : 4'b0000);
      return v;
   endfunction

   function automatic logic [3:0] syn_of(input logic [14:0] r, input int n);
      logic [3:0] s;
      s = 4'd0;
      for (int i = 0; i < n; i++) if (r[i]) s ^= alpha_pow(i);
      return s;
   endfunction

   function automatic int loc_of(input logic [3:0] s, input int n);
      for (int i = 0; i < n; i++) if (alpha_pow(i) == s) return i;
      return -1;
   endfunction

   function automatic logic [14:0] enc(input logic [10:0] msg);
      logic [14:0] c;
      c = '0;
      for (int i = 0; i < 11; i++) if (msg[i]) c ^= 15'(5'b10011) << i;
      return c;
   endfunction

   task automatic send_beat(input logic [4:0] d, input bit s, input bit e);
      int w;
      w = 0;
      bus.load = 1'b1; bus.data_in = d; bus.sop_in = s; bus.eop_in = e;
      @(negedge clk);
      while (!bus.ready && w < 100) begin
         @(negedge clk);
         w++;
      end
      if (w >= 100) begin
         n_cmp++; n_bad++;
         $display("FAIL send_beat: ready stayed 0, expected 1 within 100 cycles");
      end
      @(posedge clk); #1;
      bus.load = 1'b0; bus.sop_in = 1'b0; bus.eop_in = 1'b0;
   endtask

   task automatic send_raw(input logic [14:0] r, input int nb, input bit eop_last);
      for (int b = 0; b < nb; b++) begin
         send_beat(5'(r >> ((BB - 1 - b) * DW)), (b == 0), (b == nb - 1) && eop_last);
         if (b != nb - 1) repeat ($urandom_range(0, gap_max)) begin @(posedge clk); #1; end
      end
   endtask

   task automatic send_pkt(input logic [14:0] r, input int nb, input bit eop_last);
      logic [3:0]  s;
      logic [14:0] o;
      int          j, nerr, lat, k, w;
      o = r;
      if (nb < BB || !eop_last) begin
         nerr = 3; lat = 1;
      end else begin
         s = syn_of(r, NN);
         if (s == 4'd0) begin
            nerr = 0; lat = 1;
         end else begin
            j = loc_of(s, NN);
            if (j < 0) begin
               nerr = 2; lat = NN + 1;
            end else begin
               nerr = 1; lat = j + 2;
               o ^= 15'(1) << j;
            end
         end
      end
      for (int b = 0; b < nb; b++)
         exp_q.push_back('{data: 5'(o >> ((BB - 1 - b) * DW)), sop: (b == 0),
                           eop: (b == nb - 1), nerr: 2'(nerr)});
      send_raw(r, nb, eop_last);
      k = 0;
      @(negedge clk);
      while (!bus.valid_out && k < 60) begin
         k++;
         @(negedge clk);
      end
      chk("latency", 32'(k), 32'(lat));
      w = 0;
      while ((exp_q.size() != 0 || !bus.ready) && w < 2000) begin
         @(posedge clk); #1;
         w++;
      end
      if (w >= 2000) begin
         n_cmp++; n_bad++;
         $display("FAIL drain: %0d beats still pending, expected 0", exp_q.size());
      end
   endtask

   task automatic send2(input logic [3:0] d, input bit s, input bit e);
      int w;
      w = 0;
      bus2.load = 1'b1; bus2.data_in = d; bus2.sop_in = s; bus2.eop_in = e;
      @(negedge clk);
      while (!bus2.ready && w < 100) begin
         @(negedge clk);
         w++;
      end
      if (w >= 100) begin
         n_cmp++; n_bad++;
         $display("FAIL send2: ready stayed 0, expected 1 within 100 cycles");
      end
      @(posedge clk); #1;
      bus2.load = 1'b0; bus2.sop_in = 1'b0; bus2.eop_in = 1'b0;
   endtask

   // Scoreboard compare: every valid cycle, including stalled ones, must match the head.
   always @(negedge clk) begin
      if (rst_n && bus.valid_out) begin
         if (exp_q.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL unexpected_beat: got data %b with valid_out=1, expected no beat",
                     bus.data_out);
         end else begin
            chk("data_out", 32'(bus.data_out), 32'(exp_q[0].data));
            chk("sop_out", 32'(bus.sop_out), 32'(exp_q[0].sop));
            chk("eop_out", 32'(bus.eop_out), 32'(exp_q[0].eop));
            chk("number_errors", 32'(bus.number_errors), 32'(exp_q[0].nerr));
            if (bus.sink_ready) void'(exp_q.pop_front());
         end
      end
   end

   initial begin
      bus.sink_ready = 1'b1;
      forever begin
         @(posedge clk); #1;
         case (sink_mode)
            1: bus.sink_ready = 1'($urandom_range(0, 1));
            2: begin
               if (!bus.valid_out) begin
                  bus.sink_ready = 1'b1; stall = 0;
               end else if (stall < 4) begin
                  bus.sink_ready = 1'b0; stall++;
               end else begin
                  bus.sink_ready = 1'b1; stall = 0;
               end
            end
            default: bus.sink_ready = 1'b1;
         endcase
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [14:0] cw;
      int          kind, k, vc;
      bus.load = 1'b0; bus.sop_in = 1'b0; bus.eop_in = 1'b0; bus.data_in = '0;
      bus2.load = 1'b0; bus2.sop_in = 1'b0; bus2.eop_in = 1'b0; bus2.data_in = '0;
      bus2.sink_ready = 1'b1;
      #2 rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_ready", 32'(bus.ready), 32'd0);
      chk("rst_valid", 32'(bus.valid_out), 32'd0);
      chk("rst_sop", 32'(bus.sop_out), 32'd0);
      chk("rst_eop", 32'(bus.eop_out), 32'd0);
      chk("rst_data", 32'(bus.data_out), 32'd0);
      chk("rst_nerr", 32'(bus.number_errors), 32'd0);
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;
      chk("ready_after_release", 32'(bus.ready), 32'd1);

      // Hand-computed pins on the reference model.
      chk("model_syn_g", 32'(syn_of(15'h0013, 15)), 32'd0);
      chk("model_loc_r7", 32'(loc_of(syn_of(15'h0080, 15), 15)), 32'd7);
      chk("model_loc_r1r0", 32'(loc_of(syn_of(15'h0003, 15), 15)), 32'd4);
      chk("model_syn_n12", 32'(syn_of(15'h000D, 12)), 32'hD);
      chk("model_loc_n12", 32'(loc_of(4'hD, 12)), 32'hFFFF_FFFF);

      send_pkt(15'h0013, 3, 1'b1);
      send_pkt(15'h0080, 3, 1'b1);
      send_pkt(15'h0003, 3, 1'b1);
      send_pkt(15'h5A5A, 2, 1'b1);
      sink_mode = 2;
      send_pkt(enc(11'h5A3), 3, 1'b1);
      send_pkt(enc(11'h123) ^ 15'h0400, 3, 1'b1);

      sink_mode = 1;
      gap_max   = 2;
      for (int i = 0; i < 40; i++) begin
         kind = int'($urandom_range(0, 9));
         cw   = enc(11'($urandom));
         case (kind)
            0, 1, 2, 3: begin
               if ($urandom_range(0, 1) == 1) cw ^= 15'(1) << $urandom_range(0, 14);
               send_pkt(cw, 3, 1'b1);
            end
            4: begin
               cw ^= 15'(1) << $urandom_range(0, 14);
               cw ^= 15'(1) << $urandom_range(0, 14);
               send_pkt(cw, 3, 1'b1);
            end
            5: send_pkt(15'($urandom), 3, 1'b1);
            6: send_pkt(cw, int'($urandom_range(1, 2)), 1'b1);
            7: send_pkt(cw, 3, 1'b0);
            8: begin
               send_raw(15'($urandom), int'($urandom_range(1, 2)), 1'b0);
               send_pkt(cw, 3, 1'b1);
            end
            default: begin
               send_beat(5'($urandom), 1'b0, 1'($urandom));
               send_pkt(cw, 3, 1'b1);
            end
         endcase
      end

      // Reset while the locator search for r10 is still running.
      sink_mode = 0;
      gap_max   = 0;
      send_raw(15'h0400, 3, 1'b1);
      repeat (3) begin @(posedge clk); #1; end
      rst_n = 1'b0;
      #2;
      chk("midrst_ready", 32'(bus.ready), 32'd0);
      chk("midrst_valid", 32'(bus.valid_out), 32'd0);
      chk("midrst_sop", 32'(bus.sop_out), 32'd0);
      chk("midrst_eop", 32'(bus.eop_out), 32'd0);
      chk("midrst_data", 32'(bus.data_out), 32'd0);
      chk("midrst_nerr", 32'(bus.number_errors), 32'd0);
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;
      chk("midrst_ready_after", 32'(bus.ready), 32'd1);
      vc = 0;
      repeat (30) begin
         @(negedge clk);
         if (bus.valid_out) vc++;
      end
      chk("midrst_no_output", 32'(vc), 32'd0);

      // Shortened N=12 code: alpha^13 lies outside the searched positions.
      @(posedge clk); #1;
      send2(4'h0, 1'b1, 1'b0);
      send2(4'h0, 1'b0, 1'b0);
      send2(4'hD, 1'b0, 1'b1);
      k = 0;
      @(negedge clk);
      while (!bus2.valid_out && k < 60) begin
         k++;
         @(negedge clk);
      end
      chk("n12_latency", 32'(k), 32'd13);
      for (int b = 0; b < 3; b++) begin
         chk("n12_data", 32'(bus2.data_out), (b == 2) ? 32'hD : 32'h0);
         chk("n12_sop", 32'(bus2.sop_out), 32'(b == 0));
         chk("n12_eop", 32'(bus2.eop_out), 32'(b == 2));
         chk("n12_nerr", 32'(bus2.number_errors), 32'd2);
         @(negedge clk);
      end
      chk("n12_valid_done", 32'(bus2.valid_out), 32'd0);
      chk("queue_empty", 32'(exp_q.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
